// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter feeding one shared FIFO, with zero-latency handshake.
// Define FIFO_ARB_BURST_LOCK_EN to let a requester hold the grant for bursts of up to MAX_BURST words.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clk_en_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic [N_REQ-1:0]              req_lock_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_write_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [N_REQ-1:0]              grant_o,
    output logic [$clog2(N_REQ)-1:0]      grant_id_o
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic          arb_hit;
    logic [IW-1:0] arb_id;
    logic          has_grant;
    logic [IW-1:0] gid;
    logic          xfer;

    // Walk downward so the nearest valid index after last is the one that sticks.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid_i[(int'(last) + k) % N_REQ]) begin
                arb_hit = 1'b1;
                arb_id  = IW'((int'(last) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        has_grant = 1'b0;
        gid       = '0;
        if (!rst_i) begin
            if (state == ST_LOCKED) begin
                has_grant = 1'b1;
                gid       = owner;
            end else begin
                has_grant = arb_hit;
                gid       = arb_id;
            end
        end
    end

    assign xfer = has_grant && clk_en_i && !fifo_full_i && req_valid_i[gid];

    always_comb begin
        grant_o = '0;
        if (has_grant)
            grant_o[gid] = 1'b1;
    end

    assign grant_id_o     = gid;
    assign fifo_write_o   = xfer;
    assign req_ready_o    = xfer ? grant_o : '0;
    assign fifo_wr_data_o = has_grant ? req_data_i[gid*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            last <= IW'(N_REQ - 1);
        else if (xfer)
            last <= gid;
    end

`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst_cnt;

    // last already tracks the owner from the locking transfer onward, so exits need no fix-up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_ARB;
            owner     <= '0;
            burst_cnt <= '0;
        end else if (clk_en_i) begin
            case (state)
                ST_ARB: begin
                    if (xfer && req_lock_i[gid]) begin
                        state     <= ST_LOCKED;
                        owner     <= gid;
                        burst_cnt <= CW'(1);
                    end
                end
                default: begin
                    if (xfer) begin
                        if (!req_lock_i[owner] || burst_cnt == CW'(MAX_BURST - 1)) begin
                            state     <= ST_ARB;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + CW'(1);
                        end
                    end else if (!req_lock_i[owner] && !req_valid_i[owner]) begin
                        state     <= ST_ARB;
                        burst_cnt <= '0;
                    end
                end
            endcase
        end
    end
`else
    assign state = ST_ARB;
    assign owner = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter against a cycle-level reference model.
module tb_fifo_write_arbiter;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int MB = 4;
`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, en, full;
    logic [N-1:0]    valid, lock, ready, grant;
    logic [N*DW-1:0] data;
    logic            wr;
    logic [DW-1:0]   wr_data;
    logic [1:0]      gid;

    int errs = 0;
    int checks = 0;

    // Reference state: who spoke last, and the current burst if any.
    int m_last = N - 1;
    bit m_locked = 0;
    int m_owner = 0;
    int m_count = 0;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(en),
        .req_valid_i(valid), .req_data_i(data), .req_lock_i(lock),
        .req_ready_o(ready), .fifo_full_i(full), .fifo_write_o(wr),
        .fifo_wr_data_o(wr_data), .grant_o(grant), .grant_id_o(gid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic f, input logic e, input logic r);
        bit has;
        int g;
        bit x;
        logic [N-1:0]  eg;
        logic [DW-1:0] ed;
        valid = v; lock = l; full = f; en = e; rst = r;
        for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
        has = 0; g = 0;
        if (!r) begin
            if (m_locked) begin
                has = 1; g = m_owner;
            end else begin
                for (int k = 1; k <= N && !has; k++)
                    if (v[(m_last + k) % N]) begin has = 1; g = (m_last + k) % N; end
            end
        end
        x  = has && e && !f && v[g];
        eg = has ? N'(1 << g) : '0;
        ed = has ? data[g*DW +: DW] : '0;
        #2;
        chk("grant_id", 64'(gid), 64'(g));
        chk("grant", 64'(grant), 64'(eg));
        chk("write", 64'(wr), 64'(x));
        chk("ready", 64'(ready), x ? 64'(eg) : 64'd0);
        chk("wr_data", 64'(wr_data), 64'(ed));
        @(posedge clk);
        if (r) begin
            m_last = N - 1; m_locked = 0; m_owner = 0; m_count = 0;
        end else if (e) begin
            if (x) begin
                m_last = g;
                if (!m_locked) begin
                    if (LOCK_EN && l[g]) begin m_locked = 1; m_owner = g; m_count = 1; end
                end else begin
                    m_count++;
                    if (!l[m_owner] || m_count == MB) m_locked = 0;
                end
            end else if (m_locked && !l[m_owner] && !v[m_owner]) begin
                m_locked = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cyc('0, '0, 1'b0, 1'b1, 1'b1);
        cyc('0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; full = 1'b0; valid = '0; lock = '0; data = '0;
        @(posedge clk); #1;
        // reset holds everything quiet even with requests pending
        cyc(4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
        do_reset();
        repeat (8) cyc(4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
        do_reset();
        repeat (3) cyc(4'b0100, 4'h0, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(4'b0100, 4'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(4'b0101, 4'h0, 1'b0, 1'b1, 1'b0);
        do_reset();
        repeat (7) cyc(4'b1011, 4'b0010, 1'b0, 1'b1, 1'b0);
        do_reset();
        cyc(4'b0011, 4'b0010, 1'b0, 1'b1, 1'b0);
        cyc(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(4'b1001, 4'b0010, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(4'b1011, 4'b0010, 1'b0, 1'b1, 1'b0);
        do_reset();
        cyc(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);
        cyc(4'b0011, 4'b0010, 1'b0, 1'b0, 1'b1);
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
        do_reset();
        repeat (8) cyc(4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] rv, rl;
            rv = N'($urandom);
            rl = ($urandom_range(0, 3) != 0) ? N'($urandom) : '0;
            cyc(rv, rl, $urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 49) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
